// File: rtl/slot_display.sv
// rtl/slot_display.sv - score BCD conversion and 8-digit multiplexed 7-segment display
//
// Display stage downstream of the slot-machine FSM. Digits 7..5 show the three
// slot result digits; digits 4..0 show the score, converted to BCD by a
// sequential double-dabble engine and saturated at SCORE_SAT.
//
// Optional build macro: LEAD_ZERO_BLANK_EN
//   defined   - leading zero score digits 4..1 are blanked
//   undefined - all five score digits are shown with leading zeros
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active-low
//   resultMSB  slot digit shown on display digit 7
//   result2    slot digit shown on display digit 6
//   resultLSB  slot digit shown on display digit 5
//   score      32-bit binary score
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   an         digit enables, active-low, an[i] = digit i
//   busy       high while a BCD conversion is in progress
//   bcd_score  last completed BCD score, [19:16] = ten-thousands
module slot_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int SCORE_SAT   = 99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  resultMSB,
    input  logic [3:0]  result2,
    input  logic [3:0]  resultLSB,
    input  logic [31:0] score,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        busy,
    output logic [19:0] bcd_score
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] captured;
    logic [16:0] bin;
    logic [19:0] acc;
    logic [19:0] acc_adj;
    logic [4:0]  shift_cnt;
    logic [16:0] load_val;

    // Conversion FSM: next state and busy
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE:    if (score != captured) state_next = LOAD;
            LOAD: begin
                busy       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (shift_cnt == 5'd16) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load_val = (score >= 32'(SCORE_SAT)) ? 17'(SCORE_SAT) : score[16:0];

    // Double-dabble correction: nibbles >= 5 get +3 before the shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            captured  <= '0;
            bin       <= '0;
            acc       <= '0;
            shift_cnt <= '0;
            bcd_score <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    captured  <= score;
                    bin       <= load_val;
                    acc       <= '0;
                    shift_cnt <= '0;
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[18:0], bin, 1'b0};
                    shift_cnt  <= shift_cnt + 5'd1;
                end
                DONE:    bcd_score <= acc;
                default: ;
            endcase
        end
    end

    // Display multiplexing
    logic [CW-1:0] refresh_cnt;
    logic [2:0]    digit_idx;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    always_comb begin
        nibble = 4'd0;
        blank  = 1'b0;
        case (digit_idx)
            3'd7:    nibble = resultMSB;
            3'd6:    nibble = result2;
            3'd5:    nibble = resultLSB;
            3'd4:    nibble = bcd_score[19:16];
            3'd3:    nibble = bcd_score[15:12];
            3'd2:    nibble = bcd_score[11:8];
            3'd1:    nibble = bcd_score[7:4];
            default: nibble = bcd_score[3:0];
        endcase
`ifdef LEAD_ZERO_BLANK_EN
        // A score digit is blank only if it and every higher score digit are zero
        case (digit_idx)
            3'd4:    blank = (bcd_score[19:16] == 4'd0);
            3'd3:    blank = (bcd_score[19:12] == 8'd0);
            3'd2:    blank = (bcd_score[19:8]  == 12'd0);
            3'd1:    blank = (bcd_score[19:4]  == 16'd0);
            default: blank = 1'b0;
        endcase
`endif
    end

    always_comb begin
        seg_next = 7'h3F;
        case (nibble)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h3F;
        endcase
        if (blank) seg_next = 7'h7F;
    end

    // seg and an share one register stage so they always switch together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 7'h7F;
            an  <= 8'hFF;
        end else begin
            seg <= seg_next;
            an  <= ~(8'b1 << digit_idx);
        end
    end

endmodule

// File: doc/slot_display.md
Name: slot_display

Overview:
- Output stage directly downstream of the slot-machine FSM. Consumes the three result digits (resultMSB, result2, resultLSB) and the 32-bit score.
- Converts the score to BCD with a sequential double-dabble engine and drives an 8-digit multiplexed, common-anode 7-segment display.
- Layout: digits 7..5 show the slot results; digits 4..0 show the score.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; minimum 2.
- SCORE_SAT, 99999, score saturation value; must fit in 5 BCD digits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low.
- resultMSB  input  4  slot digit shown on display digit 7.
- result2  input  4  slot digit shown on display digit 6.
- resultLSB  input  4  slot digit shown on display digit 5.
- score  input  32  binary score from the slot FSM.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  8  digit enables, active-low; an[i] = digit i.
- busy  output  1  high while a BCD conversion is in progress.
- bcd_score  output  20  last completed BCD score, 5 nibbles; [19:16] = ten-thousands.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - seg=7'h7F, an=8'hFF, busy=0, bcd_score=20'h0.
  - FSM in IDLE; refresh counter=0; digit index=0; captured score=0.
- Conversion FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: if score != captured score, go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Capture score. Load value = min(score, SCORE_SAT), unsigned compare.
  - Put the 17-bit saturated value in the shift register; clear the 20-bit BCD accumulator; busy=1.
- SHIFT (exactly 17 cycles):
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1.
  - A 5-bit counter tracks the shifts.
- DONE (1 cycle): bcd_score <= accumulator; busy=0; next state IDLE.
- Latency: a score change seen in IDLE at edge N appears on bcd_score at edge N+19. busy is high for exactly 18 cycles.
- Score changes during LOAD/SHIFT/DONE are ignored until IDLE. IDLE then sees the mismatch and restarts, so the final bcd_score always matches the latest stable score.
- Saturation: score >= SCORE_SAT gives bcd_score=20'h99999, including score=32'hFFFFFFFF.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 3-bit digit index increments; 7 wraps to 0.
- Digit index selects the source:
  - 7 = resultMSB, 6 = result2, 5 = resultLSB.
  - 4..0 = bcd_score nibbles 4..0.
- seg and an are registered from the current index, so they change together one cycle after the index changes. an = ~(8'b1 << index); exactly one bit is low after reset is released.
- Segment encoding (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Slot digit value 10..15 shows a dash, 3F.
- Display and conversion run independently. The display reads bcd_score as registered and never shows a partial conversion.
- Reset asserted mid-conversion aborts immediately to the reset values.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: score digits 4..1 show blank (7F) while they and every higher score digit are zero. Digit 0 is always shown; slot digits are never blanked. Example: score 42 shows blank,blank,blank,4,2.
- Undefined: all five score digits are always shown, with leading zeros (00042).

Test Plan (REFRESH_DIV=4):
- Reset, release, hold score=0 -> busy stays 0; bcd_score=0; an steps FE,FD,FB,...,7F every 4 cycles; seg=40 on score digits.
- score 0->12345 one edge before IDLE sample -> busy high 18 cycles; bcd_score=20'h12345 19 edges after sample; digit 2 shows seg=30.
- score=32'hFFFFFFFF, then 100000 -> both give bcd_score=20'h99999; a second conversion runs on the change, same result.
- score 500->777 during SHIFT -> first conversion completes (bcd_score=00500), then immediate restart gives 00777; never an intermediate value.
- resultMSB=9, result2=4'hC, resultLSB=0 -> digit7 seg=10, digit6 seg=3F, digit5 seg=40.
- Drop reset mid-SHIFT with score=321 -> seg=7F, an=FF, busy=0 asynchronously. After release, conversion reruns and bcd_score=00321. With LEAD_ZERO_BLANK_EN, digits 4..3 show 7F.
